// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined bitwise logic unit.
// The operation select encoding is used by the unit and by anything that drives it.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    localparam int OP_W = 2;

endpackage

// File: rtl/logic_unit_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register drives the output, skid absorbs one
// extra entry so in_ready depends only on registered state.
//
// state | meaning
// EMPTY | main_valid=0, skid_valid=0: nothing held, in_ready=1
// ONE   | main_valid=1, skid_valid=0: one result on the output, in_ready=1
// FULL  | main_valid=1, skid_valid=1: two results held, in_ready=0
module skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          main_valid, skid_valid;
    logic [DW-1:0] main_data, skid_data;
    logic          main_valid_nxt, skid_valid_nxt;
    logic          load_main_in, load_main_skid, load_skid;
    logic          push, pop;

    assign push = in_valid & ~skid_valid;
    assign pop  = main_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (load_main_in)
                main_data <= in_data;
            else if (load_main_skid)
                main_data <= skid_data;
            if (load_skid)
                skid_data <= in_data;
        end
    end

    // In FULL no push can occur, so a pop there only ever shifts skid into main.
    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (pop) begin
            if (skid_valid) begin
                load_main_skid = 1'b1;
                skid_valid_nxt = 1'b0;
            end else if (push) begin
                load_main_in = 1'b1;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (push) begin
            if (main_valid) begin
                load_skid      = 1'b1;
                skid_valid_nxt = 1'b1;
            end else begin
                load_main_in   = 1'b1;
                main_valid_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready  = ~skid_valid;
        out_valid = main_valid;
        out_data  = main_data;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered NUM_IN-operand bitwise AND/OR/XOR/NAND unit with valid/ready skid buffering and a
// saturating transfer counter. Define LOGIC_UNIT_PIPE_DISPLAY_EN to print each delivered result.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  op_e                     in_op,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        out_count
);

    logic [WIDTH-1:0] red_and, red_or, red_xor, result;

    always_comb begin
        red_and = '1;
        red_or  = '0;
        red_xor = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            red_and = red_and & in_data[k*WIDTH +: WIDTH];
            red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
            red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
        end
        result = red_and;
        case (in_op)
            OP_AND:  result = red_and;
            OP_OR:   result = red_or;
            OP_XOR:  result = red_xor;
            OP_NAND: result = ~red_and;
            default: result = red_and;
        endcase
    end

`ifdef LOGIC_UNIT_PIPE_DISPLAY_EN
    localparam int DW = WIDTH + OP_W;
`else
    localparam int DW = WIDTH;
`endif

    logic [DW-1:0] buf_in, buf_out;

`ifdef LOGIC_UNIT_PIPE_DISPLAY_EN
    // The op rides along with the result so the print can name it at delivery time.
    assign buf_in   = {in_op, result};
    assign out_data = buf_out[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst && out_valid && out_ready)
            $display("[%0t] op=%0d c = %h", $time, buf_out[WIDTH +: OP_W], out_data);
    end
`else
    assign buf_in   = result;
    assign out_data = buf_out;
`endif

    skid_buf #(
        .DW (DW)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (buf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    always_ff @(posedge clk) begin
        if (rst)
            out_count <= '0;
        else if (out_valid && out_ready && (out_count != '1))
            out_count <= out_count + 1'b1;
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a default instance plus a CNT_W=3 twin fed the same
// stimulus; expected results come from a per-bit ones-count model of the four operations.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int WIDTH  = 8;
    localparam int NUM_IN = 2;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 3;
    localparam int DW_IN  = NUM_IN * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    op_e              in_op;
    logic [DW_IN-1:0] in_data;
    logic             out_ready;

    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             sat_in_ready, sat_out_valid;
    logic [WIDTH-1:0] sat_out_data;
    logic [SAT_W-1:0] sat_out_count;

    logic_unit_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    logic_unit_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_op(in_op),
        .in_data(in_data), .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_data(sat_out_data), .out_count(sat_out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   model_cnt = 0;
    bit   lat_chk   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Each result bit depends only on how many operands have a 1 in that position.
    function automatic logic [WIDTH-1:0] ref_result(op_e op, logic [DW_IN-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < WIDTH; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < NUM_IN; k++)
                ones += int'(d[k*WIDTH + b]);
            case (op)
                OP_AND:  r[b] = (ones == NUM_IN);
                OP_OR:   r[b] = (ones > 0);
                OP_XOR:  r[b] = (ones % 2 == 1);
                default: r[b] = (ones != NUM_IN);
            endcase
        end
        return r;
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Output-side monitor: occupancy, ordering, data, latency and counters against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            check("out_valid", longint'(out_valid), longint'(sb.size() > 0));
            check("in_ready", longint'(in_ready), longint'(sb.size() < 2));
            check("out_count", longint'(out_count), (model_cnt > 65535) ? 65535 : model_cnt);
            check("sat_count", longint'(sat_out_count), (model_cnt > 7) ? 7 : model_cnt);
            if (out_valid && sb.size() > 0)
                check("out_data", longint'(out_data), longint'(sb[0].data));
            if (sat_out_valid && sb.size() > 0)
                check("sat_out_data", longint'(sat_out_data), longint'(sb[0].data));
            if (rst) begin
                sb.delete();
                model_cnt = 0;
            end else if (out_valid && out_ready) begin
                if (sb.size() > 0) begin
                    if (sb[0].lat)
                        check("latency", cyc, sb[0].cyc + 1);
                    void'(sb.pop_front());
                end
                model_cnt++;
            end
        end
    end

    // Input-side monitor: records every accepted transaction with its expected result.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && in_valid && in_ready)
                sb.push_back('{data: ref_result(in_op, in_data), cyc: cyc, lat: lat_chk});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(op_e op, logic [DW_IN-1:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = in_ready && !rst;
            @(posedge clk);
            #1;
        end
        check("send_accepted", longint'(done), 1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        op_e              ops  [4];
        logic [WIDTH-1:0] exps [4];
        logic [DW_IN-1:0] d_a;
        int               c0;
        ops  = '{OP_AND, OP_OR, OP_XOR, OP_NAND};
        exps = '{8'h30, 8'hFC, 8'hCC, 8'hCF};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_op     = OP_OR;
        in_data   = DW_IN'($urandom);
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        repeat (3) step();
        check("reset_out_data", longint'(out_data), 0);
        check("reset_no_accept", sb.size(), 0);
        rst = 1'b0;
        c0  = cyc;

        for (int i = 0; i < 4; i++) begin
            send(ops[i], 16'h3CF0);
            if (i == 0)
                check("first_accept_cycle", cyc - c0, 1);
            check("op_result", longint'(out_data), longint'(exps[i]));
        end
        repeat (2) step();

        pulse_reset();
        c0 = cyc;
        for (int i = 0; i < 16; i++)
            send(op_e'($urandom_range(0, 3)), DW_IN'($urandom));
        check("stream_cycles", cyc - c0, 16);
        repeat (2) step();
        check("stream_count", longint'(out_count), 16);

        lat_chk   = 1'b0;
        out_ready = 1'b0;
        d_a = DW_IN'($urandom);
        send(OP_XOR, d_a);
        send(op_e'($urandom_range(0, 3)), DW_IN'($urandom));
        check("bp_in_ready_low", longint'(in_ready), 0);
        check("bp_hold_first", longint'(out_data), longint'(ref_result(OP_XOR, d_a)));
        in_valid = 1'b1;
        in_op    = OP_NAND;
        in_data  = DW_IN'($urandom);
        repeat (3) step();
        check("bp_still_held", longint'(out_data), longint'(ref_result(OP_XOR, d_a)));
        out_ready = 1'b1;
        send(OP_NAND, in_data);
        repeat (4) step();

        out_ready = 1'b0;
        send(op_e'($urandom_range(0, 3)), DW_IN'($urandom));
        send(op_e'($urandom_range(0, 3)), DW_IN'($urandom));
        pulse_reset();
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_count", longint'(out_count), 0);
        out_ready = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            in_op     = op_e'($urandom_range(0, 3));
            in_data   = DW_IN'($urandom);
            step();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        pulse_reset();
        for (int i = 0; i < 10; i++)
            send(op_e'($urandom_range(0, 3)), DW_IN'($urandom));
        repeat (3) step();
        check("sat_final", longint'(sat_out_count), 7);
        check("wide_final", longint'(out_count), 10);
        check("drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit; successor to the single-bit combinational AND gate.
- Reduces NUM_IN operands of WIDTH bits with a run-time-selected op: AND, OR, XOR or NAND.
- Valid/ready on both sides, 1-cycle latency, 2-entry skid buffer so full throughput survives backpressure.
- Saturating transfer counter for bench observability; used by the example testbenches as a device-under-test.

Parameters:
- WIDTH, 8, operand/result bit width (>=1)
- NUM_IN, 2, number of operands reduced per transaction (>=2)
- CNT_W, 16, width of the completed-transfer counter (>=1)

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  unit can accept input this cycle
- in_op  input  2  op select, logic_unit_pkg::op_e
- in_data  input  NUM_IN*WIDTH  operands; operand k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  result
- out_count  output  CNT_W  number of completed output handshakes, saturating

Behaviour:
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
- Op encoding: OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3.
- Result is the bitwise reduction over all NUM_IN operands: AND, OR, XOR, or ~AND.
- Result is computed combinationally from in_data/in_op and captured on the input handshake.
- Latency: an accepted input appears on out_data with out_valid=1 on the next cycle.
- Storage: 2-entry skid buffer with main and skid registers, each holding data plus a valid bit.
- in_ready = ~skid_valid (registered-derived, no combinational path from out_ready).
- Buffer states:
  - EMPTY: accept -> ONE.
  - ONE: accept & pop -> ONE (main reloaded); accept & ~pop -> FULL (new result to skid); pop & ~accept -> EMPTY.
  - FULL: in_ready=0; pop -> ONE (skid moves to main, skid cleared).
- Order is strictly FIFO. Results are never dropped or duplicated. out_data is stable while out_valid & ~out_ready.
- out_count increments by 1 on each output handshake and holds at 2^CNT_W-1.
- Reset (any cycle, including mid-transfer): main_valid=0, skid_valid=0, out_valid=0, out_data=0, out_count=0, in_ready=1 during reset.
  - In-flight results are discarded.
  - Inputs presented during the rst cycle are not accepted.
- X on in_op while in_valid=0 must not affect state.

Optional Feature:
- Macro: LOGIC_UNIT_PIPE_DISPLAY_EN.
- Defined: on every output handshake, $display("[%0t] op=%0d c = %h", $time, op, out_data). The op is carried alongside the data in both buffer entries.
- Not defined: no display statements and no op storage; functionally identical ports and timing.

Decomposition:
- logic_unit_pkg:
  - op_e typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND}
  - function reduce_op(op, operand vector) is not allowed in the package because widths are parametric; the reduction lives in the module.
- Sub-module skid_buf #(DW): generic 2-entry valid/ready skid buffer with clk/rst.
  - logic_unit_pipe instantiates it with DW=WIDTH, or WIDTH+2 under the display macro.
  - The counter stays in the top module.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_count=0, in_ready=1, no acceptance; first accept only on the cycle after rst drops.
- Ops, WIDTH=8, NUM_IN=2, operands 0xF0/0x3C, out_ready=1:
  - AND -> 0x30
  - OR -> 0xFC
  - XOR -> 0xCC
  - NAND -> 0xCF
  - each result valid exactly 1 cycle after accept.
- Streaming: 16 back-to-back inputs with out_ready=1 -> 16 results in order on consecutive cycles, in_ready never drops, out_count=16.
- Backpressure:
  - out_ready=0, present 3 inputs -> first two accepted, in_ready=0 from the cycle after the second, out_data holds the first result.
  - Raise out_ready -> results emerge in order, third input accepted once in_ready returns.
- Reset mid-operation: buffer FULL, assert rst one cycle -> out_valid=0 next cycle, count=0, buffered results never appear.
- Saturation: CNT_W=3, 10 transfers -> out_count reads 7 and holds.
